seq_div_16bit: RTL and testbench

- Multi-cycle restoring divider for the MIPS datapath; the inverse counterpart to the multiply path beside the 16-bit ALU.
- Accepts a dividend/divisor pair on a start pulse, iterates one quotient bit per clock, then returns quotient and remainder with a done pulse.
- The control unit stalls on busy; it feeds the HI/LO-style result registers.

---
 rtl/seq_div_16bit_pkg.sv | 15 +
 rtl/seq_div_16bit_step.sv | 28 ++
 rtl/seq_div_16bit.sv | 136 +++++++++++++
 tb/tb_seq_div_16bit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/seq_div_16bit_pkg.sv
// Shared MIPS datapath definitions used by the sequential divider.
package mips_defs;

  localparam int DATA_W = 16;

  localparam logic [DATA_W-1:0] DIV_ZERO_QUOT = {DATA_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } div_state_t;

endpackage

// File: rtl/seq_div_16bit_step.sv
// One combinational restoring-division step: shift {rem,quo} left, trial-subtract divisor.
module div_step_16bit #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem < divisor on entry, so the WIDTH+1 bit trial never wraps and its MSB is the sign.
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, divisor};

  always_comb begin
    rem_next = shifted[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_next    = trial[WIDTH-1:0];
      quo_next[0] = 1'b1;
    end
  end

endmodule

// File: rtl/seq_div_16bit.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Define SIGNED_DIV_EN to add the sgn input and the two's-complement FIXUP cycle.
module seq_div_16bit
  import mips_defs::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef SIGNED_DIV_EN
  input  logic             sgn,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  div_state_t state, state_next;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [WIDTH-1:0] rem_n, quo_n;
  logic             accept;
  logic             steps_done;
  logic             need_fix;
  logic [WIDTH-1:0] a_mag, b_mag;

`ifdef SIGNED_DIV_EN
  logic sgn_q, neg_quo_q, neg_rem_q;
  logic a_neg, b_neg;

  assign a_neg    = sgn & dividend[WIDTH-1];
  assign b_neg    = sgn & divisor[WIDTH-1];
  assign a_mag    = a_neg ? (~dividend + 1'b1) : dividend;
  assign b_mag    = b_neg ? (~divisor + 1'b1) : divisor;
  assign need_fix = sgn_q;
`else
  assign a_mag    = dividend;
  assign b_mag    = divisor;
  assign need_fix = 1'b0;
`endif

  assign steps_done = (cnt == CNT_W'(WIDTH));

  div_step_16bit #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (rem_n),
    .quo_next (quo_n)
  );

  // start/accept: a request is taken only in IDLE or DONE; elsewhere it is dropped.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = (divisor == '0) ? DONE : RUN;
        end else if (state == DONE) begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (steps_done) state_next = need_fix ? FIXUP : DONE;
      end
      FIXUP:   state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
`ifdef SIGNED_DIV_EN
      sgn_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else if (accept) begin
      cnt      <= '0;
      rem_q    <= '0;
      quo_q    <= a_mag;
      dvs_q    <= b_mag;
      div_zero <= (divisor == '0);
`ifdef SIGNED_DIV_EN
      sgn_q     <= sgn;
      neg_quo_q <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
`endif
      // Divide-by-zero skips iteration and publishes its fixed result immediately.
      if (divisor == '0) begin
        quotient  <= {WIDTH{1'b1}};
        remainder <= dividend;
      end
    end else if (state == RUN) begin
      if (!steps_done) begin
        rem_q <= rem_n;
        quo_q <= quo_n;
        cnt   <= cnt + CNT_W'(1);
      end else if (!need_fix) begin
        quotient  <= quo_q;
        remainder <= rem_q;
      end
    end
`ifdef SIGNED_DIV_EN
    else if (state == FIXUP) begin
      quotient  <= neg_quo_q ? (~quo_q + 1'b1) : quo_q;
      remainder <= neg_rem_q ? (~rem_q + 1'b1) : rem_q;
    end
`endif
  end

  assign busy = (state == RUN) || (state == FIXUP);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_div_16bit.sv
// Randomized and directed bench for seq_div_16bit (unsigned build) against a plain-arithmetic model.
module tb_seq_div_16bit;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, div_zero;
  logic [W-1:0] quotient, remainder;

  int total = 0;
  int bad   = 0;

  logic [32:0] exp_q[$];

  seq_div_16bit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected {div_zero, quotient, remainder} from ordinary integer division.
  function automatic logic [32:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned ai, bi;
    ai = a;
    bi = b;
    if (bi == 0) return {1'b1, 16'hFFFF, a};
    return {1'b0, 16'(ai / bi), 16'(ai % bi)};
  endfunction

  // Drives a one-cycle start; returns just after the sampling edge.
  task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after the sampling edge until done is seen; timeout flagged by ok=0.
  task automatic wait_done(output int lat, output bit ok);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    ok = done;
  endtask

  task automatic check_result(input string tag, input int lat, input bit ok, input int exp_lat);
    logic [32:0] e;
    e = exp_q.pop_front();
    chk({tag, "_done"}, 32'(ok), 32'd1);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_quo"}, 32'(quotient), 32'(e[31:16]));
    chk({tag, "_rem"}, 32'(remainder), 32'(e[15:0]));
    chk({tag, "_dz"}, 32'(div_zero), 32'(e[32]));
  endtask

  task automatic run_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat;
    bit ok;
    exp_q.push_back(model(a, b));
    do_start(a, b);
    if (b != 0) chk({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(lat, ok);
    check_result(tag, lat, ok, (b == 0) ? 0 : W + 1);
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat;
    bit ok;
    bit seen;
    logic [W-1:0] a, b;

    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quo", 32'(quotient), 32'd0);
    chk("rst_rem", 32'(remainder), 32'd0);
    chk("rst_dz", 32'(div_zero), 32'd0);
    rst = 1'b0;

    run_one("d100_7", 16'd100, 16'd7);
    run_one("dffff_1", 16'hFFFF, 16'd1);
    run_one("d3_10", 16'd3, 16'd10);
    run_one("d5_0", 16'd5, 16'd0);
    run_one("d9_3", 16'd9, 16'd3);

    // Start pulsed while busy must be ignored.
    exp_q.push_back(model(16'd100, 16'd7));
    do_start(16'd100, 16'd7);
    repeat (4) begin @(posedge clk); #1; end
    start = 1'b1; dividend = 16'd50; divisor = 16'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, ok);
    check_result("ign", lat + 5, ok, W + 1);

    // Start held in the DONE cycle is accepted back-to-back.
    exp_q.push_back(model(16'd50, 16'd5));
    start = 1'b1; dividend = 16'd50; divisor = 16'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_done(lat, ok);
    check_result("b2b", lat, ok, W + 1);
    @(posedge clk);
    #1;

    // Reset mid-operation aborts with no done pulse.
    do_start(16'd1000, 16'd3);
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_quo", 32'(quotient), 32'd0);
    chk("abort_rem", 32'(remainder), 32'd0);
    chk("abort_dz", 32'(div_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin @(posedge clk); #1; if (done) seen = 1'b1; end
    chk("abort_nodone", 32'(seen), 32'd0);
    run_one("after_rst", 16'd1000, 16'd3);

    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0: b = 16'($urandom_range(0, 15));
        1: b = 16'($urandom_range(1, 255));
        default: b = 16'($urandom);
      endcase
      run_one("rand", a, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
